// File: rtl/ascon_permutation_iter_pkg.sv
// Shared types and constants for the iterative ASCON permutation engine:
// the 320-bit state layout, the 5-bit S-box, the round constant and the
// per-lane rotation pairs of the linear layer.
package ascon_permutation_iter_pkg;

  // Five 64-bit lanes; x0 is the most significant lane of the packed struct.
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  // Engine control states, also exported for debug.
  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_DONE = 2'd2
  } fsm_state_t;

  // S-box indexed by the bit column {x0[i],x1[i],x2[i],x3[i],x4[i]}.
  localparam logic [4:0] SBOX_TABLE [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  // Rotation amounts (a_k, b_k) of the diffusion layer for lanes x0..x4.
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  // Round constant XORed into x2[7:0]: r=0 -> F0, r=11 -> 4B.
  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  // Single S-box lookup.
  function automatic logic [4:0] sbox(input logic [4:0] x);
    return SBOX_TABLE[x];
  endfunction

  // Rotate a 64-bit lane right by n (0 < n < 64).
  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_permutation_iter_if.sv
// Load/unload bus of the permutation engine.
//
// Handshake rules for both channels: a transfer happens on a rising clock
// edge where valid and ready are both 1. The source holds valid and its data
// stable until that edge; ready may be asserted independently of valid.
// Load channel: in_valid_i / in_ready_o carrying nr_rounds_i and state_i.
// Unload channel: out_valid_o / out_ready_i carrying state_o and out_err_o;
// out_err_o qualifies the result and is meaningful only with out_valid_o.
interface ascon_permutation_iter_if;
  import ascon_permutation_iter_pkg::*;

  logic       in_valid_i;
  logic       in_ready_o;
  logic [3:0] nr_rounds_i;
  type_state  state_i;
  logic       out_valid_o;
  logic       out_ready_i;
  type_state  state_o;
  logic       out_err_o;
  logic       busy_o;

  // Engine side.
  modport slave (
    input  in_valid_i, nr_rounds_i, state_i, out_ready_i,
    output in_ready_o, out_valid_o, state_o, out_err_o, busy_o
  );

  // Mode-controller side.
  modport master (
    output in_valid_i, nr_rounds_i, state_i, out_ready_i,
    input  in_ready_o, out_valid_o, state_o, out_err_o, busy_o
  );

endinterface

// File: rtl/ascon_permutation_iter_round.sv
// One combinational ASCON round: constant addition on x2, 64 parallel
// 5-bit S-boxes across the lanes, then the per-lane linear diffusion.
module ascon_permutation_iter_round
  import ascon_permutation_iter_pkg::*;
(
  input  logic [3:0] r_i,
  input  type_state  s_i,
  output type_state  s_o
);

  logic [63:0] x [5];
  logic [63:0] y [5];
  logic [63:0] z [5];

  // Unpack the lanes and add the round constant to the low byte of x2.
  assign x[0] = s_i.x0;
  assign x[1] = s_i.x1;
  assign x[2] = s_i.x2 ^ {56'd0, round_const(r_i)};
  assign x[3] = s_i.x3;
  assign x[4] = s_i.x4;

  // Substitution layer: each bit column goes through the S-box, x0 as MSB.
  always_comb begin
    logic [4:0] sb;
    sb = '0;
    for (int k = 0; k < 5; k++) begin
      y[k] = '0;
    end
    for (int i = 0; i < 64; i++) begin
      sb = sbox({x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]});
      y[0][i] = sb[4];
      y[1][i] = sb[3];
      y[2][i] = sb[2];
      y[3][i] = sb[1];
      y[4][i] = sb[0];
    end
  end

  // Linear layer: every lane mixes with two rotated copies of itself.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      z[k] = y[k] ^ ror64(y[k], ROT_A[k]) ^ ror64(y[k], ROT_B[k]);
    end
  end

  assign s_o.x0 = z[0];
  assign s_o.x1 = z[1];
  assign s_o.x2 = z[2];
  assign s_o.x3 = z[3];
  assign s_o.x4 = z[4];

endmodule

// File: rtl/ascon_permutation_iter.sv
// Iterative ASCON permutation p^n. A request loads the 320-bit state and
// the round count; the engine then applies UNROLL rounds per clock over
// round indices MAX_ROUNDS-n .. MAX_ROUNDS-1 and presents the result until
// it is unloaded. Illegal round counts return the input state with an error.
module ascon_permutation_iter
  import ascon_permutation_iter_pkg::*;
#(
  parameter int UNROLL     = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic                        clock_i,
  input  logic                        resetb_i,
  ascon_permutation_iter_if.slave     bus,
  output fsm_state_t                  fsm_state_o
);

  if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
    $error("ascon_permutation_iter: UNROLL must be 1 or 2");
  end

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);
  localparam logic [3:0] STEP  = 4'(UNROLL);

  fsm_state_t fsm_q;
  fsm_state_t fsm_d;
  type_state  state_q;
  logic [3:0] round_q;
  logic [3:0] round_next;
  logic       err_q;
  logic       accept;
  logic       legal;
  logic       last;

  // Round chain: stage k sees the state after k rounds of this clock.
  type_state chain [UNROLL + 1];

  assign chain[0] = state_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    ascon_permutation_iter_round u_round (
      .r_i (round_q + 4'(k)),
      .s_i (chain[k]),
      .s_o (chain[k + 1])
    );
  end

  // A round count is usable when it is 1..MAX_ROUNDS and a whole number of
  // clocks at the current unroll factor.
  assign legal = (bus.nr_rounds_i != 4'd0) && (bus.nr_rounds_i <= MAX_R) &&
                 ((UNROLL == 1) || (bus.nr_rounds_i[0] == 1'b0));

  assign accept     = (fsm_q == FSM_IDLE) && bus.in_valid_i;
  assign round_next = round_q + STEP;
  assign last       = (round_next == MAX_R);

  // Control state register.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q <= FSM_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state and handshake outputs; all outputs decode from registers only.
  always_comb begin
    fsm_d           = fsm_q;
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.busy_o      = 1'b0;
    case (fsm_q)
      FSM_IDLE: begin
        bus.in_ready_o = 1'b1;
        if (accept) begin
          fsm_d = legal ? FSM_RUN : FSM_DONE;
        end
      end
      FSM_RUN: begin
        bus.busy_o = 1'b1;
        if (last) begin
          fsm_d = FSM_DONE;
        end
      end
      FSM_DONE: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) begin
          fsm_d = FSM_IDLE;
        end
      end
      default: begin
        fsm_d = FSM_IDLE;
      end
    endcase
  end

  // Datapath: load on accept, advance UNROLL rounds per RUN clock, drop the
  // error flag when the result is unloaded.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= '0;
      round_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (fsm_q)
        FSM_IDLE: begin
          if (accept) begin
            state_q <= bus.state_i;
            err_q   <= !legal;
            round_q <= legal ? (MAX_R - bus.nr_rounds_i) : 4'd0;
          end
        end
        FSM_RUN: begin
          state_q <= chain[UNROLL];
          round_q <= round_next;
        end
        FSM_DONE: begin
          if (bus.out_ready_i) begin
            err_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.state_o   = state_q;
  assign bus.out_err_o = err_q;
  assign fsm_state_o   = fsm_q;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Bench for ascon_permutation_iter: one engine with UNROLL=1 and one with
// UNROLL=2 share clock and reset. Expected states come from a bitsliced
// reference model and are queued when a request is accepted, then popped
// and compared when the engine presents its result.
module tb_ascon_permutation_iter;
  import ascon_permutation_iter_pkg::*;

  logic clock_i = 1'b0;
  logic resetb_i;

  always #5 clock_i = ~clock_i;

  ascon_permutation_iter_if bus1();
  ascon_permutation_iter_if bus2();
  fsm_state_t fsm1;
  fsm_state_t fsm2;

  ascon_permutation_iter #(.UNROLL(1), .MAX_ROUNDS(12)) u_dut1 (
    .clock_i     (clock_i),
    .resetb_i    (resetb_i),
    .bus         (bus1),
    .fsm_state_o (fsm1)
  );

  ascon_permutation_iter #(.UNROLL(2), .MAX_ROUNDS(12)) u_dut2 (
    .clock_i     (clock_i),
    .resetb_i    (resetb_i),
    .bus         (bus2),
    .fsm_state_o (fsm2)
  );

  int checks = 0;
  int errors = 0;

  type_state exp_q[$];
  logic      exp_err_q[$];

  // ---------------- reference model ----------------
  function automatic logic [63:0] rot(input logic [63:0] v, input int k);
    return (v >> k) | (v << (64 - k));
  endfunction

  function automatic type_state model_round(input type_state s, input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state o;
    x0 = s.x0; x1 = s.x1; x3 = s.x3; x4 = s.x4;
    x2 = s.x2 ^ 64'((15 - r) * 16 + r);
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    o.x0 = x0 ^ rot(x0, 19) ^ rot(x0, 28);
    o.x1 = x1 ^ rot(x1, 61) ^ rot(x1, 39);
    o.x2 = x2 ^ rot(x2, 1)  ^ rot(x2, 6);
    o.x3 = x3 ^ rot(x3, 10) ^ rot(x3, 17);
    o.x4 = x4 ^ rot(x4, 7)  ^ rot(x4, 41);
    return o;
  endfunction

  function automatic type_state model_perm(input type_state s, input int n);
    type_state t;
    t = s;
    for (int r = 12 - n; r < 12; r++) t = model_round(t, r);
    return t;
  endfunction

  function automatic logic is_legal(input int n, input int unroll);
    return (n >= 1) && (n <= 12) && ((n % unroll) == 0);
  endfunction

  function automatic type_state rand_state();
    type_state s;
    s.x0 = {$urandom, $urandom}; s.x1 = {$urandom, $urandom};
    s.x2 = {$urandom, $urandom}; s.x3 = {$urandom, $urandom};
    s.x4 = {$urandom, $urandom};
    return s;
  endfunction

  // ---------------- DUT access by selector (1 or 2) ----------------
  function automatic int unroll_of(input int sel);
    return (sel == 2) ? 2 : 1;
  endfunction
  function automatic logic dut_in_ready(input int sel);
    return (sel == 2) ? bus2.in_ready_o : bus1.in_ready_o;
  endfunction
  function automatic logic dut_valid(input int sel);
    return (sel == 2) ? bus2.out_valid_o : bus1.out_valid_o;
  endfunction
  function automatic logic dut_err(input int sel);
    return (sel == 2) ? bus2.out_err_o : bus1.out_err_o;
  endfunction
  function automatic logic dut_busy(input int sel);
    return (sel == 2) ? bus2.busy_o : bus1.busy_o;
  endfunction
  function automatic type_state dut_state(input int sel);
    return (sel == 2) ? bus2.state_o : bus1.state_o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int sel, input logic v, input logic [3:0] n,
                         input type_state s);
    if (sel == 2) begin
      bus2.in_valid_i = v; bus2.nr_rounds_i = n; bus2.state_i = s;
    end else begin
      bus1.in_valid_i = v; bus1.nr_rounds_i = n; bus1.state_i = s;
    end
  endtask

  task automatic set_out_ready(input int sel, input logic v);
    if (sel == 2) bus2.out_ready_i = v;
    else bus1.out_ready_i = v;
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input int sel, input int n, input type_state s);
    int   budget;
    logic legal;
    budget = 0;
    legal  = is_legal(n, unroll_of(sel));
    while (!dut_in_ready(sel) && budget < 50) begin
      @(negedge clock_i);
      budget++;
    end
    if (!dut_in_ready(sel)) begin
      checks++; errors++;
      $display("FAIL send_ready dut%0d: in_ready_o=0 after %0d cycles, required 1", sel, budget);
      return;
    end
    set_req(sel, 1'b1, 4'(n), s);
    @(posedge clock_i);
    exp_q.push_back(legal ? model_perm(s, n) : s);
    exp_err_q.push_back(!legal);
    @(negedge clock_i);
    set_req(sel, 1'b0, 4'h0, '0);
  endtask

  // Counts rising edges after the accept edge until out_valid_o is seen.
  task automatic wait_valid(input int sel, output int edges);
    edges = 0;
    while (!dut_valid(sel) && edges < 60) begin
      @(negedge clock_i);
      edges++;
    end
  endtask

  task automatic unload(input int sel);
    set_out_ready(sel, 1'b1);
    @(posedge clock_i);
    @(negedge clock_i);
    set_out_ready(sel, 1'b0);
  endtask

  task automatic pop_expect(output type_state s, output logic e);
    if (exp_q.size() == 0) begin
      s = 'x; e = 1'bx;
    end else begin
      s = exp_q.pop_front(); e = exp_err_q.pop_front();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetb_i = 1'b0;
    set_req(1, 1'b0, 4'h0, '0); set_req(2, 1'b0, 4'h0, '0);
    set_out_ready(1, 1'b0); set_out_ready(2, 1'b0);
    #12;
    checks++; if (bus1.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus1.in_ready_o); end
    checks++; if (bus1.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus1.out_valid_o); end
    checks++; if (bus1.out_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", bus1.out_err_o); end
    checks++; if (bus1.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus1.busy_o); end
    checks++; if (bus1.state_o !== type_state'(0)) begin errors++; $display("FAIL reset_state: got %h, required 0", bus1.state_o); end
    checks++; if (fsm1 !== FSM_IDLE || fsm2 !== FSM_IDLE) begin errors++; $display("FAIL reset_fsm: got %0d/%0d, required 0/0", fsm1, fsm2); end
    checks++; if (bus2.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready2: got %b, required 1", bus2.in_ready_o); end
    @(negedge clock_i);
    resetb_i = 1'b1;
    @(negedge clock_i);
  endtask

  task automatic test_one_round();
    type_state s, e;
    logic ee;
    int lat;
    s = '0;
    send(1, 1, s);
    wait_valid(1, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL one_round_latency: got %0d, required 1", lat); end
    checks++; if (bus1.state_o.x4 !== 64'h0) begin errors++; $display("FAIL one_round_x4: got %h, required 0", bus1.state_o.x4); end
    pop_expect(e, ee);
    checks++; if (bus1.out_err_o !== ee) begin errors++; $display("FAIL one_round_err: got %b, required %b", bus1.out_err_o, ee); end
    checks++; if (bus1.state_o !== e) begin errors++; $display("FAIL one_round_state: got %h, required %h", bus1.state_o, e); end
    unload(1);
  endtask

  task automatic test_init_p12();
    type_state s, e, r1;
    logic ee;
    int lat;
    s.x0 = 64'h80400c0600000000;
    s.x1 = 64'h0001020304050607; s.x2 = 64'h08090a0b0c0d0e0f;
    s.x3 = 64'h0001020304050607; s.x4 = 64'h08090a0b0c0d0e0f;
    send(1, 12, s);
    checks++; if (bus1.busy_o !== 1'b1 || bus1.in_ready_o !== 1'b0) begin errors++; $display("FAIL p12_busy: busy=%b in_ready=%b, required 1/0", bus1.busy_o, bus1.in_ready_o); end
    wait_valid(1, lat);
    checks++; if (lat !== 12) begin errors++; $display("FAIL p12_latency_u1: got %0d, required 12", lat); end
    pop_expect(e, ee);
    checks++; if (bus1.state_o !== e || bus1.out_err_o !== ee) begin errors++; $display("FAIL p12_state_u1: got %h, required %h", bus1.state_o, e); end
    r1 = bus1.state_o;
    unload(1);
    send(2, 12, s);
    wait_valid(2, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL p12_latency_u2: got %0d, required 6", lat); end
    pop_expect(e, ee);
    checks++; if (bus2.state_o !== e || bus2.out_err_o !== ee) begin errors++; $display("FAIL p12_state_u2: got %h, required %h", bus2.state_o, e); end
    checks++; if (bus2.state_o !== r1) begin errors++; $display("FAIL p12_u1_vs_u2: got %h, required %h", bus2.state_o, r1); end
    unload(2);
  endtask

  task automatic test_back_to_back();
    type_state sa, sb, e, snap;
    logic ee;
    int lat;
    sa = rand_state(); sb = rand_state();
    send(1, 6, sa);
    set_req(1, 1'b1, 4'd8, sb);
    wait_valid(1, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_latency_a: got %0d, required 6", lat); end
    snap = bus1.state_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_i);
      checks++;
      if ({bus1.out_valid_o, bus1.in_ready_o, bus1.state_o} !== {1'b1, 1'b0, snap}) begin
        errors++;
        $display("FAIL b2b_hold[%0d]: valid=%b in_ready=%b state=%h, required 1/0/%h", i, bus1.out_valid_o, bus1.in_ready_o, bus1.state_o, snap);
      end
    end
    pop_expect(e, ee);
    checks++; if (bus1.state_o !== e) begin errors++; $display("FAIL b2b_state_a: got %h, required %h", bus1.state_o, e); end
    set_out_ready(1, 1'b1);
    @(posedge clock_i);
    @(negedge clock_i);
    set_out_ready(1, 1'b0);
    checks++; if (bus1.in_ready_o !== 1'b1 || bus1.out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_after_unload: in_ready=%b valid=%b, required 1/0", bus1.in_ready_o, bus1.out_valid_o); end
    @(posedge clock_i);
    exp_q.push_back(model_perm(sb, 8));
    exp_err_q.push_back(1'b0);
    @(negedge clock_i);
    set_req(1, 1'b0, 4'h0, '0);
    wait_valid(1, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency_b: got %0d, required 8", lat); end
    pop_expect(e, ee);
    checks++; if (bus1.state_o !== e || bus1.out_err_o !== ee) begin errors++; $display("FAIL b2b_state_b: got %h, required %h", bus1.state_o, e); end
    unload(1);
  endtask

  task automatic test_illegal();
    int sel_tab [3] = '{1, 1, 2};
    int n_tab   [3] = '{0, 13, 7};
    type_state s, e;
    logic ee;
    int lat;
    for (int i = 0; i < 3; i++) begin
      s = rand_state();
      send(sel_tab[i], n_tab[i], s);
      wait_valid(sel_tab[i], lat);
      checks++; if (lat !== 0) begin errors++; $display("FAIL illegal_latency n=%0d: got %0d extra edges, required 0", n_tab[i], lat); end
      pop_expect(e, ee);
      checks++; if (dut_err(sel_tab[i]) !== ee) begin errors++; $display("FAIL illegal_err n=%0d: got %b, required %b", n_tab[i], dut_err(sel_tab[i]), ee); end
      checks++; if (dut_state(sel_tab[i]) !== e) begin errors++; $display("FAIL illegal_state n=%0d: got %h, required %h", n_tab[i], dut_state(sel_tab[i]), e); end
      unload(sel_tab[i]);
      checks++; if (dut_err(sel_tab[i]) !== 1'b0 || dut_valid(sel_tab[i]) !== 1'b0) begin errors++; $display("FAIL illegal_clear n=%0d: err=%b valid=%b, required 0/0", n_tab[i], dut_err(sel_tab[i]), dut_valid(sel_tab[i])); end
    end
  endtask

  task automatic test_reset_mid_run();
    type_state s, e;
    logic ee;
    int lat;
    s = rand_state();
    send(1, 12, s);
    repeat (4) @(negedge clock_i);
    #2 resetb_i = 1'b0;
    #1;
    checks++;
    if ({bus1.busy_o, bus1.in_ready_o, bus1.out_valid_o, bus1.out_err_o} !== 4'b0100) begin
      errors++;
      $display("FAIL midrun_reset_ctrl: busy/in_ready/valid/err=%b%b%b%b, required 0100", bus1.busy_o, bus1.in_ready_o, bus1.out_valid_o, bus1.out_err_o);
    end
    checks++; if (bus1.state_o !== type_state'(0)) begin errors++; $display("FAIL midrun_reset_state: got %h, required 0", bus1.state_o); end
    exp_q.delete();
    exp_err_q.delete();
    @(negedge clock_i);
    resetb_i = 1'b1;
    @(negedge clock_i);
    s = rand_state();
    send(1, 12, s);
    wait_valid(1, lat);
    checks++; if (lat !== 12) begin errors++; $display("FAIL midrun_rerun_latency: got %0d, required 12", lat); end
    pop_expect(e, ee);
    checks++; if (bus1.state_o !== e || bus1.out_err_o !== ee) begin errors++; $display("FAIL midrun_rerun_state: got %h, required %h", bus1.state_o, e); end
    unload(1);
  endtask

  task automatic test_valid_toggle();
    type_state s, e;
    logic ee;
    int lat;
    s = rand_state();
    send(1, 8, s);
    lat = 0;
    while (!bus1.out_valid_o && lat < 60) begin
      set_req(1, lat[0], 4'($urandom_range(1, 12)), rand_state());
      @(negedge clock_i);
      lat++;
    end
    set_req(1, 1'b0, 4'h0, '0);
    checks++; if (lat !== 8) begin errors++; $display("FAIL toggle_latency: got %0d, required 8", lat); end
    pop_expect(e, ee);
    checks++; if (bus1.state_o !== e || bus1.out_err_o !== ee) begin errors++; $display("FAIL toggle_state: got %h, required %h", bus1.state_o, e); end
    unload(1);
  endtask

  task automatic test_random();
    type_state s, e;
    logic ee;
    int sel, n, lat;
    for (int i = 0; i < 6; i++) begin
      sel = (i % 2) + 1;
      n   = (sel == 2) ? 2 * $urandom_range(1, 6) : $urandom_range(1, 12);
      s   = rand_state();
      send(sel, n, s);
      wait_valid(sel, lat);
      checks++; if (lat !== n / unroll_of(sel)) begin errors++; $display("FAIL random_latency dut%0d n=%0d: got %0d, required %0d", sel, n, lat, n / unroll_of(sel)); end
      pop_expect(e, ee);
      checks++; if (dut_state(sel) !== e || dut_err(sel) !== ee) begin errors++; $display("FAIL random_state dut%0d n=%0d: got %h, required %h", sel, n, dut_state(sel), e); end
      unload(sel);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_one_round();
    test_init_p12();
    test_back_to_back();
    test_illegal();
    test_reset_mid_run();
    test_valid_toggle();
    test_random();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
